chain_seq_ctrl: RTL and testbench
=================================

// Module: chain_seq_ctrl
// PURPOSE
//  Sequencer for the mini-SoC register-chain datapath. On start it seeds r1 from init_num, then
//  walks the chain r[i+1] <= r[i] + STEP up to r[LAST] through one regfile write port.
//  It also shares the single regfile read port between the chain walk and the switch-selected LED display.
//  Sits in soc_mini_top between the board I/O (switch, init_num, led) and the regfile.
// PARAMETERS
//  DW    32  regfile data width (>=16)
//  AW    5   regfile address width
//  LAST  5   highest register written by the chain; legal range 2..2^AW-1
//  STEP  1   increment added per link, DW bits
// PORTS
//  clk       in   1   clock, all state on rising edge
//  reset     in   1   asynchronous, active-high reset
//  start     in   1   one-cycle pulse; honoured only in IDLE or DONE
//  init_num  in   8   seed value, zero-extended to DW
//  switch    in   8   display register select; bits [AW-1:0] used, upper bits ignored
//  rf_raddr  out  AW  regfile read address; read data is combinational, same cycle
//  rf_rdata  in   DW  regfile read data; r0 reads 0
//  rf_we     out  1   regfile write enable
//  rf_waddr  out  AW  regfile write address
//  rf_wdata  out  DW  regfile write data
//  busy      out  1   high in INIT/READ/WRITE
//  done      out  1   high in DONE
//  led       out  16  registered low 16 bits of r[switch]
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, tmp=0, led=0, rf_we=0, busy=0, done=0. Regfile contents untouched.
//  FSM (one state per cycle):
//   IDLE : start -> INIT, else stay.
//   INIT : rf_we=1, rf_waddr=1, rf_wdata={0,init_num}; idx<=1; -> READ.
//   READ : rf_raddr=idx; tmp<=rf_rdata; -> WRITE.
//   WRITE: rf_we=1, rf_waddr=idx+1, rf_wdata=tmp+STEP (mod 2^DW);
//          if idx+1==LAST -> DONE, else idx<=idx+1, -> READ.
//   DONE : done=1; start -> INIT (full restart, reseeded from current init_num); else stay.
//  rf_we is 0 outside INIT/WRITE; rf_waddr/rf_wdata are don't-care when rf_we=0.
//  init_num is sampled only in INIT; later changes do not affect a walk in progress.
//  Latency: start seen in IDLE at cycle 0 -> INIT cycle 1 -> done first high at cycle 2*LAST
//   (LAST=5: done at cycle 10, r1..r5 written at end of cycles 1,3,5,7,9).
//  start during INIT/READ/WRITE is ignored (not queued).
//  Read-port arbitration: the chain owns rf_raddr in READ only. In all other states
//   rf_raddr=switch[AW-1:0] and led<=rf_rdata[15:0] every cycle; in READ led holds.
//   Display therefore lags a switch change by 1 cycle when idle, at most 2 cycles when busy.
//  switch selecting r0 -> led=0x0000. Writes to r0 never issued (waddr always >=1).
//  reset asserted mid-walk: immediate return to IDLE, rf_we drops asynchronously;
//   already-written registers keep their values; a new start restarts from r1.
// TESTING
//  1 init_num=2, STEP=1, LAST=5, start pulse -> writes r1..r5 = 2,3,4,5,6; done at cycle 10; switch=5 -> led=0x0006.
//  2 DW=16, init_num=0xFF, STEP=0xFFFF -> r1=0x00FF,r2=0x00FE,...,r5=0x00FB (mod-2^DW wrap); led=0x00FB for switch=5.
//  3 start pulsed again in READ and WRITE cycles -> ignored; write sequence and done cycle identical to test 1.
//  4 reset asserted in the WRITE cycle that targets r3 -> r3 not written, busy=0,led=0 immediately; r1,r2 retain 2,3.
//  5 after DONE, set init_num=7, pulse start -> r1..r5 = 7..11; switch=0 -> led=0x0000; switch=0x23 (AW=5) -> shows r3=0x0009.
//  6 switch changed 0->4 while busy -> led updates within 2 cycles, never shows value from a READ-cycle address.

Source files
------------

// File: rtl/chain_seq_ctrl.sv
// Register-chain sequencer: seeds r1, then walks r[i+1] = r[i] + STEP up to r[LAST]
// through one regfile write port, and shares the regfile read port with the LED display.
module chain_seq_ctrl #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int LAST = 5,
  parameter logic [DW-1:0] STEP = {{(DW-1){1'b0}}, 1'b1}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    init_num,
  input  logic [7:0]    switch,
  output logic [AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          busy,
  output logic          done,
  output logic [15:0]   led
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [DW-1:0] tmp_reg, tmp_next;
  logic [15:0]   led_reg, led_next;
  logic [AW-1:0] idx_plus1;

  assign idx_plus1 = idx_reg + AW'(1);

  // Only the low AW switch bits select a register; the rest are deliberately ignored.
  generate
    if (AW < 8) begin : g_sw_unused
      logic unused_switch_bits;
      assign unused_switch_bits = ^switch[7:AW];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    tmp_next   = tmp_reg;
    led_next   = led_reg;
    rf_we      = 1'b0;
    rf_waddr   = idx_plus1;
    rf_wdata   = tmp_reg + STEP;
    rf_raddr   = switch[AW-1:0];

    // The chain borrows the read port only in READ; the display keeps it otherwise.
    if (state_reg == S_READ) begin
      rf_raddr = idx_reg;
    end else begin
      led_next = rf_rdata[15:0];
    end

    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_INIT;
      end
      S_INIT: begin
        rf_we      = 1'b1;
        rf_waddr   = AW'(1);
        rf_wdata   = {{(DW-8){1'b0}}, init_num};
        idx_next   = AW'(1);
        state_next = S_READ;
      end
      S_READ: begin
        tmp_next   = rf_rdata;
        state_next = S_WRITE;
      end
      S_WRITE: begin
        rf_we = 1'b1;
        if (idx_plus1 == AW'(LAST)) begin
          state_next = S_DONE;
        end else begin
          idx_next   = idx_plus1;
          state_next = S_READ;
        end
      end
      S_DONE: begin
        if (start) state_next = S_INIT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      tmp_reg   <= '0;
      led_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      tmp_reg   <= tmp_next;
      led_reg   <= led_next;
    end
  end

  assign busy = (state_reg == S_INIT) || (state_reg == S_READ) || (state_reg == S_WRITE);
  assign done = (state_reg == S_DONE);
  assign led  = led_reg;

endmodule

// File: tb/tb_chain_seq_ctrl.sv
// Directed bench for chain_seq_ctrl: a default instance (DW=32, STEP=1) and a
// wrap-around instance (DW=16, STEP=0xFFFF), each backed by a small regfile model.
module tb_chain_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, start_b;
  logic [7:0]  init_a, init_b, sw_a, sw_b;
  logic [4:0]  raddr_a, waddr_a, raddr_b, waddr_b;
  logic [31:0] rdata_a, wdata_a;
  logic [15:0] rdata_b, wdata_b;
  logic        we_a, busy_a, done_a, we_b, busy_b, done_b;
  logic [15:0] led_a, led_b;

  logic [31:0] rf_a [32];
  logic [15:0] rf_b [32];

  int n_checks = 0;
  int n_fail   = 0;

  chain_seq_ctrl dut_a (
    .clk(clk), .reset(reset), .start(start_a), .init_num(init_a), .switch(sw_a),
    .rf_raddr(raddr_a), .rf_rdata(rdata_a), .rf_we(we_a), .rf_waddr(waddr_a),
    .rf_wdata(wdata_a), .busy(busy_a), .done(done_a), .led(led_a)
  );

  chain_seq_ctrl #(.DW(16), .AW(5), .LAST(5), .STEP(16'hFFFF)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .init_num(init_b), .switch(sw_b),
    .rf_raddr(raddr_b), .rf_rdata(rdata_b), .rf_we(we_b), .rf_waddr(waddr_b),
    .rf_wdata(wdata_b), .busy(busy_b), .done(done_b), .led(led_b)
  );

  // Regfile models: synchronous write, combinational read, r0 reads zero.
  always @(posedge clk) begin
    if (we_a) rf_a[waddr_a] <= wdata_a;
    if (we_b) rf_b[waddr_b] <= wdata_b;
  end
  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : rf_a[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 16'd0 : rf_b[raddr_b];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full walk on instance A from IDLE/DONE; optionally pulses start during READ and WRITE.
  task automatic walk_a(input logic [7:0] init, input bit poke);
    init_a  = init;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) tick();
      start_a = poke && (c == 2 || c == 3);
      if (c == 10) begin
        check_eq("done_at_10", 32'(done_a), 32'd1);
        check_eq("busy_at_10", 32'(busy_a), 32'd0);
        check_eq("we_at_10", 32'(we_a), 32'd0);
      end else if (c % 2 == 1) begin
        check_eq("we_write", 32'(we_a), 32'd1);
        check_eq("waddr", 32'(waddr_a), 32'((c + 1) / 2));
        check_eq("wdata", wdata_a, 32'(init) + 32'((c - 1) / 2));
        check_eq("done_early", 32'(done_a), 32'd0);
        $display("cycle %0d: write r%0d <= 0x%0h", c, waddr_a, wdata_a);
      end else begin
        check_eq("we_read", 32'(we_a), 32'd0);
        check_eq("raddr_read", 32'(raddr_a), 32'(c / 2));
        check_eq("busy_read", 32'(busy_a), 32'd1);
      end
    end
    start_a = 1'b0;
  endtask

  logic [15:0] t6_led [2:11];
  logic [15:0] t2_rf  [1:5];

  initial begin
    t6_led = '{16'd0, 16'd0, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd33, 16'd33};
    t2_rf  = '{16'h00FF, 16'h00FE, 16'h00FD, 16'h00FC, 16'h00FB};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    init_a = 8'd0; init_b = 8'd0; sw_a = 8'd5; sw_b = 8'd5;
    tick(); tick();
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_led", 32'(led_a), 32'd0);
    check_eq("rst_we", 32'(we_a), 32'd0);
    check_eq("rst_raddr", 32'(raddr_a), 32'd5);
    reset = 1'b0;
    tick();

    // Test 1: init 2 -> r1..r5 = 2..6, display r5
    walk_a(8'd2, 1'b0);
    for (int i = 1; i <= 5; i++) check_eq("t1_rf", rf_a[i], 32'(i + 1));
    tick();
    check_eq("t1_led", 32'(led_a), 32'h0006);
    check_eq("t1_done_hold", 32'(done_a), 32'd1);

    // Test 3: restart from DONE with start pokes mid-walk
    walk_a(8'd2, 1'b1);
    tick();
    check_eq("t3_led", 32'(led_a), 32'h0006);
    check_eq("t3_done", 32'(done_a), 32'd1);

    // Test 4: reset in the WRITE cycle targeting r3 (r3 still holds 4)
    init_a = 8'd20; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick(); tick();
    check_eq("t4_waddr", 32'(waddr_a), 32'd3);
    reset = 1'b1;
    #1;
    check_eq("t4_we", 32'(we_a), 32'd0);
    check_eq("t4_busy", 32'(busy_a), 32'd0);
    check_eq("t4_led", 32'(led_a), 32'd0);
    tick();
    reset = 1'b0;
    check_eq("t4_r1", rf_a[1], 32'd20);
    check_eq("t4_r2", rf_a[2], 32'd21);
    check_eq("t4_r3", rf_a[3], 32'd4);
    walk_a(8'd2, 1'b0);

    // Test 5: reseed 7 from DONE, r0 and aliased switch select
    walk_a(8'd7, 1'b0);
    for (int i = 1; i <= 5; i++) check_eq("t5_rf", rf_a[i], 32'(i + 6));
    sw_a = 8'h00;
    tick();
    check_eq("t5_led_r0", 32'(led_a), 32'h0000);
    sw_a = 8'h23;
    tick();
    check_eq("t5_led_r3", 32'(led_a), 32'h0009);

    // Test 6: switch 0 -> 4 during a busy walk (init 30), led never shows READ data
    sw_a = 8'h00;
    tick();
    init_a = 8'd30; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 2; c <= 11; c++) begin
      tick();
      check_eq("t6_led", 32'(led_a), 32'(t6_led[c]));
      if (c == 2) sw_a = 8'h04;
    end
    $display("t6: display walk finished, led 0x%0h", led_a);

    // Test 2: DW=16, STEP=0xFFFF wrap
    init_b = 8'hFF; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    check_eq("t2_done", 32'(done_b), 32'd1);
    tick();
    check_eq("t2_led", 32'(led_b), 32'h00FB);
    for (int i = 1; i <= 5; i++) begin
      check_eq("t2_rf", 32'(rf_b[i]), 32'(t2_rf[i]));
      $display("t2: r%0d = 0x%0h", i, rf_b[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
